lsu_mem_master: RTL

// - Load/store initiator between pipeline MEM stage and word-addressed data memory bus.
// - Takes one request at a time; byte/half/word lane steering; load sign/zero extension.
// - Waits for grant and read data, watchdogs lost read data, returns one response pulse.
// - busy drives the hazard unit to stall the pipeline.

---
 rtl/lsu_mem_master_if.sv | 38 +++
 rtl/lsu_mem_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master_if.sv
// Bundles the pipeline request/response channel and the data-memory bus of lsu_mem_master.
// Request side: a transfer happens when req_valid & req_ready; response and mem_gnt/mem_rvalid are single-cycle pulses.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata, dbg_state
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, dbg_state
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator with lane steering, load extension and read-data watchdog.
// Optional alignment checking is enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_mem_master #(
    parameter int MEM_DEPTH   = 1024,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_master_if.master bus
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          accept;
    logic          illegal;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    assign accept = bus.req_valid & bus.req_ready;

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                lane_be    = 4'b0001 << bus.req_addr[1:0];
                lane_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                lane_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
        illegal = (bus.req_size == 2'b11) ||
                  ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_DEPTH));
`ifdef LSU_MISALIGN_CHK_EN
        illegal = illegal ||
                  ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                  ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`endif
    end

    // Load data is extracted from the live bus word using the offset captured at accept.
    always_comb begin
        shifted   = bus.mem_rdata;
        load_data = bus.mem_rdata;
        case (size_q)
            2'b00: begin
                shifted   = bus.mem_rdata >> {off_q, 3'b000};
                load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                shifted   = bus.mem_rdata >> {off_q[1], 4'b0000};
                load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    off_d   = bus.req_addr[1:0];
                    addr_d  = {2'b00, bus.req_addr[31:2]};
                    be_d    = lane_be;
                    wdata_d = lane_wdata;
                    rdata_d = '0;
                    err_d   = illegal;
                    state_d = illegal ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Data arriving on the watchdog's last cycle still wins.
                if (bus.mem_rvalid) begin
                    rdata_d = load_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = rst & (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.mem_req    = (state_q == S_REQ);
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_be     = be_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.dbg_state  = state_q;
endmodule
